// File: rtl/turn_sequencer.sv
// Turn sequencer for the sum-to-15 game: owns the board, referees human and engine moves.
// Optional engine watchdog is compiled in when ENGINE_TIMEOUT_EN is defined.
module turn_sequencer #(
    parameter int COMPUTER_FIRST = 0,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       newGame,
    input  logic [3:0] hMove,
    input  logic       hEnter,
    input  logic [3:0] cMove,
    input  logic       cValid,
    output logic       engStep,
    output logic [8:0] humanMask,
    output logic [8:0] compMask,
    output logic [3:0] lastMove,
    output logic [3:0] turnCount,
    output logic       illegal,
    output logic       gameOver,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        WAIT_HUM = 2'd0,
        ENG_REQ  = 2'd1,
        WAIT_ENG = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam state_t START_STATE = (COMPUTER_FIRST != 0) ? ENG_REQ : WAIT_HUM;

    state_t     state_q, state_d;
    logic [8:0] human_mask_q, human_mask_d;
    logic [8:0] comp_mask_q, comp_mask_d;
    logic [3:0] last_move_q, last_move_d;
    logic [3:0] turn_count_q, turn_count_d;
    logic       illegal_q, illegal_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic       eng_step_q, eng_step_d;
    logic       henter_q, henter_d;
    logic       armed_q, armed_d;

    logic       h_rise;
    logic [8:0] h_bit, c_bit, taken;
    logic [8:0] h_mask_next, c_mask_next;
    logic [3:0] count_next;
    logic       tmo_hit;

    function automatic logic [8:0] move_bit(input logic [3:0] mv);
        move_bit = 9'd0;
        if (mv >= 4'd1 && mv <= 4'd9) begin
            move_bit = 9'd1 << (mv - 4'd1);
        end
    endfunction

    // Bit i-1 represents number i; each constant is one sum-15 triple.
    function automatic logic has_triple(input logic [8:0] m);
        has_triple = ((m & 9'h062) == 9'h062) || ((m & 9'h111) == 9'h111) ||
                     ((m & 9'h08C) == 9'h08C) || ((m & 9'h10A) == 9'h10A) ||
                     ((m & 9'h054) == 9'h054) || ((m & 9'h0A1) == 9'h0A1) ||
                     ((m & 9'h092) == 9'h092) || ((m & 9'h038) == 9'h038);
    endfunction

`ifdef ENGINE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = TMO_LOAD;
        if (state_q == WAIT_ENG) begin
            tmo_d = (tmo_q == '0) ? tmo_q : tmo_q - TMO_W'(1);
        end
        tmo_hit = (state_q == WAIT_ENG) && (tmo_q == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= TMO_LOAD;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
`endif

    // armed_q blocks a level that was already high at restart from counting as an edge.
    assign h_rise      = hEnter & ~henter_q & armed_q;
    assign h_bit       = move_bit(hMove);
    assign c_bit       = move_bit(cMove);
    assign taken       = human_mask_q | comp_mask_q;
    assign h_mask_next = human_mask_q | h_bit;
    assign c_mask_next = comp_mask_q | c_bit;
    assign count_next  = turn_count_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        human_mask_d = human_mask_q;
        comp_mask_d  = comp_mask_q;
        last_move_d  = last_move_q;
        turn_count_d = turn_count_q;
        illegal_d    = illegal_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        eng_step_d   = 1'b0;
        henter_d     = hEnter;
        armed_d      = armed_q | ~hEnter;

        case (state_q)
            WAIT_HUM: begin
                if (h_rise) begin
                    if (h_bit != 9'd0 && (h_bit & taken) == 9'd0) begin
                        human_mask_d = h_mask_next;
                        last_move_d  = hMove;
                        turn_count_d = count_next;
                        illegal_d    = 1'b0;
                        if (has_triple(h_mask_next)) begin
                            game_over_d = 1'b1;
                            winner_d    = 2'b01;
                            state_d     = DONE;
                        end else if (count_next == 4'd9) begin
                            game_over_d = 1'b1;
                            winner_d    = 2'b11;
                            state_d     = DONE;
                        end else begin
                            state_d = ENG_REQ;
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ENG_REQ: begin
                eng_step_d = 1'b1;
                state_d    = WAIT_ENG;
            end
            WAIT_ENG: begin
                if (cValid) begin
                    if (c_bit != 9'd0 && (c_bit & taken) == 9'd0) begin
                        comp_mask_d  = c_mask_next;
                        last_move_d  = cMove;
                        turn_count_d = count_next;
                        illegal_d    = 1'b0;
                        if (has_triple(c_mask_next)) begin
                            game_over_d = 1'b1;
                            winner_d    = 2'b10;
                            state_d     = DONE;
                        end else if (count_next == 4'd9) begin
                            game_over_d = 1'b1;
                            winner_d    = 2'b11;
                            state_d     = DONE;
                        end else begin
                            state_d = WAIT_HUM;
                        end
                    end else begin
                        game_over_d = 1'b1;
                        winner_d    = 2'b01;
                        state_d     = DONE;
                    end
                end else if (tmo_hit) begin
                    game_over_d = 1'b1;
                    winner_d    = 2'b01;
                    state_d     = DONE;
                end
            end
            default: begin
            end
        endcase

        if (newGame) begin
            state_d      = START_STATE;
            human_mask_d = 9'd0;
            comp_mask_d  = 9'd0;
            last_move_d  = 4'd0;
            turn_count_d = 4'd0;
            illegal_d    = 1'b0;
            game_over_d  = 1'b0;
            winner_d     = 2'b00;
            eng_step_d   = 1'b0;
            henter_d     = 1'b0;
            armed_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= START_STATE;
            human_mask_q <= 9'd0;
            comp_mask_q  <= 9'd0;
            last_move_q  <= 4'd0;
            turn_count_q <= 4'd0;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            eng_step_q   <= 1'b0;
            henter_q     <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            human_mask_q <= human_mask_d;
            comp_mask_q  <= comp_mask_d;
            last_move_q  <= last_move_d;
            turn_count_q <= turn_count_d;
            illegal_q    <= illegal_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            eng_step_q   <= eng_step_d;
            henter_q     <= henter_d;
            armed_q      <= armed_d;
        end
    end

    assign engStep   = eng_step_q;
    assign humanMask = human_mask_q;
    assign compMask  = comp_mask_q;
    assign lastMove  = last_move_q;
    assign turnCount = turn_count_q;
    assign illegal   = illegal_q;
    assign gameOver  = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: a reference game model queues expected board state per move.
module tb_turn_sequencer;

    logic       clock = 1'b0;
    logic       reset, newGame, hEnter, cValid;
    logic [3:0] hMove, cMove;
    logic       engStep, illegal, gameOver;
    logic [8:0] humanMask, compMask;
    logic [3:0] lastMove, turnCount;
    logic [1:0] winner;

    always #5 clock = ~clock;

    turn_sequencer #(.COMPUTER_FIRST(0), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .newGame(newGame), .hMove(hMove), .hEnter(hEnter),
        .cMove(cMove), .cValid(cValid), .engStep(engStep), .humanMask(humanMask),
        .compMask(compMask), .lastMove(lastMove), .turnCount(turnCount), .illegal(illegal),
        .gameOver(gameOver), .winner(winner)
    );

    typedef struct {
        string      tag;
        logic [8:0] h, c;
        logic [3:0] last, cnt;
        logic       ill, over;
        logic [1:0] win;
        int         steps;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int eng_seen = 0, eng_served = 0;

    logic [8:0] m_h, m_c;
    logic [3:0] m_last, m_cnt;
    logic       m_ill, m_over;
    logic [1:0] m_win;
    int         m_steps = 0;

    always @(negedge clock) if (engStep === 1'b1) eng_seen++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, req);
        end
    endtask

    function automatic bit model_win(input logic [8:0] m);
        for (int a = 1; a <= 9; a++)
            for (int b = a + 1; b <= 9; b++)
                for (int c = b + 1; c <= 9; c++)
                    if (m[a-1] && m[b-1] && m[c-1] && (a + b + c == 15)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_h = '0; m_c = '0; m_last = '0; m_cnt = '0;
        m_ill = 1'b0; m_over = 1'b0; m_win = 2'b00;
    endtask

    task automatic model_human(input int mv);
        logic [8:0] b;
        if (m_over) return;
        b = (mv >= 1 && mv <= 9) ? (9'd1 << (mv - 1)) : 9'd0;
        if (b == 0 || ((m_h | m_c) & b) != 0) begin
            m_ill = 1'b1;
            return;
        end
        m_h = m_h | b; m_last = 4'(mv); m_cnt = m_cnt + 4'd1; m_ill = 1'b0;
        if (model_win(m_h)) begin m_over = 1'b1; m_win = 2'b01; end
        else if (m_cnt == 4'd9) begin m_over = 1'b1; m_win = 2'b11; end
        else m_steps++;
    endtask

    task automatic model_comp(input int mv);
        logic [8:0] b;
        if (m_over) return;
        b = (mv >= 1 && mv <= 9) ? (9'd1 << (mv - 1)) : 9'd0;
        if (b == 0 || ((m_h | m_c) & b) != 0) begin
            m_over = 1'b1; m_win = 2'b01;
            return;
        end
        m_c = m_c | b; m_last = 4'(mv); m_cnt = m_cnt + 4'd1; m_ill = 1'b0;
        if (model_win(m_c)) begin m_over = 1'b1; m_win = 2'b10; end
        else if (m_cnt == 4'd9) begin m_over = 1'b1; m_win = 2'b11; end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.h = m_h; e.c = m_c; e.last = m_last; e.cnt = m_cnt;
        e.ill = m_ill; e.over = m_over; e.win = m_win; e.steps = m_steps;
        exp_q.push_back(e);
    endtask

    task automatic compare_top();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({e.tag, ".humanMask"}, 32'(humanMask), 32'(e.h));
        check({e.tag, ".compMask"},  32'(compMask),  32'(e.c));
        check({e.tag, ".lastMove"},  32'(lastMove),  32'(e.last));
        check({e.tag, ".turnCount"}, 32'(turnCount), 32'(e.cnt));
        check({e.tag, ".illegal"},   32'(illegal),   32'(e.ill));
        check({e.tag, ".gameOver"},  32'(gameOver),  32'(e.over));
        check({e.tag, ".winner"},    32'(winner),    32'(e.win));
        check({e.tag, ".engSteps"},  32'(eng_seen),  32'(e.steps));
    endtask

    task automatic human(input int mv);
        hEnter = 1'b0;
        @(negedge clock);
        hMove = 4'(mv); hEnter = 1'b1;
        model_human(mv);
        push_exp($sformatf("human%0d", mv));
        repeat (3) @(negedge clock);
        hEnter = 1'b0;
        @(negedge clock);
        compare_top();
    endtask

    task automatic eng(input int mv);
        int n = 0;
        while (eng_seen <= eng_served && n < 20) begin
            @(negedge clock); #1; n++;
        end
        if (eng_seen <= eng_served) begin
            check("eng_step_wait", 32'(eng_seen), 32'(eng_served + 1));
            return;
        end
        eng_served++;
        cMove = 4'(mv); cValid = 1'b1;
        model_comp(mv);
        push_exp($sformatf("eng%0d", mv));
        @(negedge clock);
        cValid = 1'b0;
        @(negedge clock);
        compare_top();
    endtask

    task automatic new_game();
        @(negedge clock);
        newGame = 1'b1;
        @(negedge clock);
        newGame = 1'b0;
        model_reset();
        eng_served = m_steps;
    endtask

    task automatic play_game(input int mv[9], input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) human(mv[i]);
            else eng(mv[i]);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; newGame = 1'b0; hEnter = 1'b0; cValid = 1'b0;
        hMove = 4'd0; cMove = 4'd0;
        model_reset();
        repeat (3) @(negedge clock);
        push_exp("reset");
        compare_top();
        check("reset.engStep", 32'(engStep), 32'd0);
        reset = 1'b0;

        // human 5 then engine duplicates 5: forfeit
        play_game('{5, 5, 0, 0, 0, 0, 0, 0, 0}, 2);

        // human resubmits a taken number
        new_game();
        human(5); eng(1); human(5); human(2);

        // human 2,7,6 wins; a further submit is ignored
        new_game();
        play_game('{2, 1, 7, 3, 6, 0, 0, 0, 0}, 5);
        human(4);

        // engine completes 2,5,8
        new_game();
        play_game('{1, 2, 3, 5, 4, 8, 0, 0, 0}, 6);

        // full board, no triple: draw
        new_game();
        play_game('{2, 7, 6, 5, 9, 1, 3, 4, 8}, 9);

        // human completes 2,9,4 on move 9: win beats draw
        new_game();
        play_game('{2, 7, 6, 5, 9, 1, 3, 8, 4}, 9);

        // newGame coincident with an hEnter edge, level held afterwards
        @(negedge clock);
        hMove = 4'd5; hEnter = 1'b1; newGame = 1'b1;
        model_reset();
        eng_served = m_steps;
        @(negedge clock);
        newGame = 1'b0;
        push_exp("held_level");
        repeat (5) @(negedge clock);
        compare_top();
        human(5);

        // async reset while engStep is high
        new_game();
        hEnter = 1'b0;
        @(negedge clock);
        hMove = 4'd3; hEnter = 1'b1;
        model_human(3);
        n = 0;
        while (engStep !== 1'b1 && n < 10) begin
            @(negedge clock); #1; n++;
        end
        check("async.engStep_seen", 32'(engStep), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async.engStep", 32'(engStep), 32'd0);
        check("async.humanMask", 32'(humanMask), 32'd0);
        model_reset();
        eng_served = m_steps;
        @(negedge clock);
        reset = 1'b0; hEnter = 1'b0;
        push_exp("after_async");
        @(negedge clock);
        compare_top();

        // engine withholds cValid; hEnter in WAIT_ENG must be ignored
        new_game();
        human(5);
        @(negedge clock);
        hMove = 4'd5; hEnter = 1'b1;
`ifdef ENGINE_TIMEOUT_EN
        m_over = 1'b1; m_win = 2'b01;
`endif
        push_exp("engine_silent");
        repeat (2) @(negedge clock);
        hEnter = 1'b0;
        repeat (100) @(negedge clock);
        compare_top();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
